// File: rtl/ball_kinematics_ctrl.sv
// Per-ball fixed-point motion engine: strike load, per-frame friction, collision reflection, cushion bounce.
// Define BALL_POCKET_EN to add pocket detection with a POCKETED state and respawn on the next strike.
module ball_kinematics_ctrl #(
    parameter int POS_W     = 11,
    parameter int FRAC_BITS = 6,
    parameter int SPEED_W   = 12,
    parameter int MAX_SPEED = 1024,
    parameter int FRICTION  = 2,
    parameter int MIN_SPEED = 8,
    parameter int INITIAL_X = 100,
    parameter int INITIAL_Y = 220,
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 591,
    parameter int Y_MIN     = 16,
    parameter int Y_MAX     = 431
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      strike_valid,
    input  logic signed [SPEED_W-1:0] strike_vx,
    input  logic signed [SPEED_W-1:0] strike_vy,
    output logic                      strike_ready,
    input  logic                      collision,
    input  logic [3:0]                HitEdgeCode,
    output logic signed [POS_W-1:0]   topLeftX,
    output logic signed [POS_W-1:0]   topLeftY,
    output logic                      moving,
    output logic                      pocketed
);
    localparam int FP_W  = POS_W + FRAC_BITS + 1;
    localparam int PIX_W = FP_W - FRAC_BITS;

    typedef logic signed [FP_W-1:0]    fpos_t;
    typedef logic signed [SPEED_W-1:0] spd_t;
    typedef logic signed [PIX_W-1:0]   pix_t;
    typedef enum logic [1:0] {IDLE, ROLLING, POCKETED} state_t;

    function automatic spd_t sat_speed(input spd_t v);
        if (v > spd_t'(MAX_SPEED))  return spd_t'(MAX_SPEED);
        if (v < -spd_t'(MAX_SPEED)) return -spd_t'(MAX_SPEED);
        return v;
    endfunction

    function automatic spd_t abs_speed(input spd_t v);
        return v[SPEED_W-1] ? -v : v;
    endfunction

    // Friction never crosses zero: small speeds snap to rest instead.
    function automatic spd_t apply_friction(input spd_t v);
        if (abs_speed(v) <= spd_t'(MIN_SPEED)) return '0;
        return v[SPEED_W-1] ? v + spd_t'(FRICTION) : v - spd_t'(FRICTION);
    endfunction

    function automatic fpos_t to_fixed(input int px);
        return fpos_t'(px) <<< FRAC_BITS;
    endfunction

    function automatic pix_t to_pixel(input fpos_t p);
        return pix_t'(p >>> FRAC_BITS);
    endfunction

    state_t state;
    fpos_t  pos_x, pos_y;
    spd_t   vx, vy;
    logic   fpos_x, fneg_x, fpos_y, fneg_y;

    spd_t   vx_f, vy_f, vx_c, vy_c, vx_n, vy_n;
    fpos_t  px_s, py_s, px_c, py_c;

    always_comb begin
        vx_f = fpos_x ? abs_speed(vx) : (fneg_x ? -abs_speed(vx) : vx);
        vy_f = fpos_y ? abs_speed(vy) : (fneg_y ? -abs_speed(vy) : vy);
        px_s = pos_x + fpos_t'(vx_f);
        py_s = pos_y + fpos_t'(vy_f);
        px_c = px_s;
        vx_c = vx_f;
        py_c = py_s;
        vy_c = vy_f;
        if (to_pixel(px_s) < pix_t'(X_MIN)) begin
            px_c = to_fixed(X_MIN);
            vx_c = abs_speed(vx_f);
        end else if (to_pixel(px_s) > pix_t'(X_MAX)) begin
            px_c = to_fixed(X_MAX);
            vx_c = -abs_speed(vx_f);
        end
        if (to_pixel(py_s) < pix_t'(Y_MIN)) begin
            py_c = to_fixed(Y_MIN);
            vy_c = abs_speed(vy_f);
        end else if (to_pixel(py_s) > pix_t'(Y_MAX)) begin
            py_c = to_fixed(Y_MAX);
            vy_c = -abs_speed(vy_f);
        end
        vx_n = apply_friction(vx_c);
        vy_n = apply_friction(vy_c);
    end

`ifdef BALL_POCKET_EN
    localparam int POCKET_R = 12;
    localparam int MID_X    = (X_MIN + X_MAX) / 2;

    // Ball centre = topLeft + radius for both ball and pocket, so the radius cancels out.
    function automatic logic near_pocket(input pix_t x, input pix_t y);
        int   dx, dy;
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                dx = int'(x) - ((i == 0) ? X_MIN : (i == 1) ? MID_X : X_MAX);
                dy = int'(y) - ((j == 0) ? Y_MIN : Y_MAX);
                if (dx * dx + dy * dy <= POCKET_R * POCKET_R) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    logic hit_pocket;
    assign hit_pocket = near_pocket(to_pixel(px_c), to_pixel(py_c));
`else
    assign pocketed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pos_x        <= to_fixed(INITIAL_X);
            pos_y        <= to_fixed(INITIAL_Y);
            vx           <= '0;
            vy           <= '0;
            {fpos_x, fneg_x, fpos_y, fneg_y} <= '0;
            strike_ready <= 1'b1;
            moving       <= 1'b0;
`ifdef BALL_POCKET_EN
            pocketed     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (strike_valid) begin
                        vx <= sat_speed(strike_vx);
                        vy <= sat_speed(strike_vy);
                        {fpos_x, fneg_x, fpos_y, fneg_y} <= '0;
                        if (sat_speed(strike_vx) != '0 || sat_speed(strike_vy) != '0) begin
                            state        <= ROLLING;
                            strike_ready <= 1'b0;
                            moving       <= 1'b1;
                        end
                    end
                end
                ROLLING: begin
                    if (startOfFrame) begin
                        pos_x <= px_c;
                        pos_y <= py_c;
                        {fpos_x, fneg_x, fpos_y, fneg_y} <= '0;
`ifdef BALL_POCKET_EN
                        if (hit_pocket) begin
                            state    <= POCKETED;
                            vx       <= '0;
                            vy       <= '0;
                            moving   <= 1'b0;
                            pocketed <= 1'b1;
                        end else
`endif
                        begin
                            vx <= vx_n;
                            vy <= vy_n;
                            if (vx_n == '0 && vy_n == '0) begin
                                state        <= IDLE;
                                moving       <= 1'b0;
                                strike_ready <= 1'b1;
                            end
                        end
                    end
                    // A pulse on the frame edge itself lands in the cleared flags for the next frame.
                    if (collision) begin
                        if (HitEdgeCode[3] && !HitEdgeCode[1]) begin
                            fpos_x <= 1'b1;
                            fneg_x <= 1'b0;
                        end else if (HitEdgeCode[1] && !HitEdgeCode[3]) begin
                            fpos_x <= 1'b0;
                            fneg_x <= 1'b1;
                        end
                        if (HitEdgeCode[2] && !HitEdgeCode[0]) begin
                            fpos_y <= 1'b1;
                            fneg_y <= 1'b0;
                        end else if (HitEdgeCode[0] && !HitEdgeCode[2]) begin
                            fpos_y <= 1'b0;
                            fneg_y <= 1'b1;
                        end
                    end
                end
`ifdef BALL_POCKET_EN
                POCKETED: begin
                    if (strike_valid) begin
                        state        <= IDLE;
                        pos_x        <= to_fixed(INITIAL_X);
                        pos_y        <= to_fixed(INITIAL_Y);
                        pocketed     <= 1'b0;
                        strike_ready <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign topLeftX = POS_W'(pos_x >>> FRAC_BITS);
    assign topLeftY = POS_W'(pos_y >>> FRAC_BITS);

endmodule
